// File: rtl/status_pkg.sv
// Shared types and constants for the ALU status unit.
package status_pkg;

  // Operation codes carried on the 3-bit op port; 5..7 are reserved.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ADC = 3'd2,
    OP_SBC = 3'd3,
    OP_CMP = 3'd4
  } op_e;

  // Bit positions inside the {Z,N,C,V} flag vector and the flag_we mask.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // True for the operations that use the inverted second operand.
  function automatic logic op_is_sub(input logic [2:0] op);
    logic res;
    case (op)
      OP_SUB:  res = 1'b1;
      OP_SBC:  res = 1'b1;
      OP_CMP:  res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/status_reg_pipe_add_flags.sv
// Combinational WIDTH-bit adder/subtractor with carry-in and Z/N/C/V flag generation.
module add_flags #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o,
  output logic             v_o,
  output logic             z_o,
  output logic             n_o
);

  logic [WIDTH-1:0] bb_s;
  logic [WIDTH:0]   s_s;

  // Single (WIDTH+1)-bit add; subtraction is a + ~b + cin so C=1 means no borrow.
  always_comb begin
    if (sub_i) begin
      bb_s = ~b_i;
    end else begin
      bb_s = b_i;
    end
    s_s = {1'b0, a_i} + {1'b0, bb_s} + {{WIDTH{1'b0}}, cin_i};
  end

  assign sum_o = s_s[WIDTH-1:0];
  assign c_o   = s_s[WIDTH];
  // Signed overflow: operands of equal sign giving a result of the other sign.
  assign v_o   = (a_i[WIDTH-1] == bb_s[WIDTH-1]) && (s_s[WIDTH-1] != a_i[WIDTH-1]);
  assign z_o   = (s_s[WIDTH-1:0] == {WIDTH{1'b0}});
  assign n_o   = s_s[WIDTH-1];

endmodule

// File: rtl/status_reg_pipe.sv
// ALU status unit: valid/ready wrapped add/sub with registered result, Z/N/C/V flags,
// sticky overflow and a saturating overflow-event counter.
module status_reg_pipe
  import status_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       flag_we,
  input  logic             clr_sticky,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wr_en,
  output logic [3:0]       flags,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wr_en_q, wr_en_d;
  logic [3:0]       flags_q, flags_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fire_s;
  logic             op_valid_s;
  logic             op_wr_s;
  logic             sub_s;
  logic             cin_s;
  logic [WIDTH-1:0] sum_s;
  logic             c_s, v_s, z_s, n_s;
  logic [3:0]       new_flags_s;
  logic             v_event_s;

  assign in_ready = !out_valid_q || out_ready;
  assign fire_s   = in_valid && in_ready;

  // Decode op into adder controls; carry-in for ADC/SBC comes from the flag register.
  always_comb begin
    op_valid_s = 1'b1;
    op_wr_s    = 1'b1;
    sub_s      = op_is_sub(op);
    cin_s      = 1'b0;
    case (op)
      OP_ADD: begin
        cin_s = 1'b0;
      end
      OP_SUB: begin
        cin_s = 1'b1;
      end
      OP_ADC: begin
        cin_s = flags_q[FLAG_C];
      end
      OP_SBC: begin
        cin_s = flags_q[FLAG_C];
      end
      OP_CMP: begin
        cin_s   = 1'b1;
        op_wr_s = 1'b0;
      end
      default: begin
        op_valid_s = 1'b0;
        op_wr_s    = 1'b0;
        cin_s      = 1'b0;
      end
    endcase
  end

  add_flags #(
    .WIDTH(WIDTH)
  ) u_add_flags (
    .a_i   (a),
    .b_i   (b),
    .sub_i (sub_s),
    .cin_i (cin_s),
    .sum_o (sum_s),
    .c_o   (c_s),
    .v_o   (v_s),
    .z_o   (z_s),
    .n_o   (n_s)
  );

  assign new_flags_s = {z_s, n_s, c_s, v_s};
  assign v_event_s   = fire_s && op_valid_s && v_s;

  // Output handshake and result/wr_en load; result only changes on an accepted op.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    wr_en_d     = wr_en_q;
    if (fire_s) begin
      out_valid_d = 1'b1;
      wr_en_d     = op_wr_s;
      if (op_valid_s) begin
        result_d = sum_s;
      end else begin
        result_d = {WIDTH{1'b0}};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Per-flag masked update from the current op's own result; reserved ops leave flags alone.
  always_comb begin
    flags_d = flags_q;
    for (int i = 0; i < 4; i++) begin
      if (fire_s && op_valid_s && flag_we[i]) begin
        flags_d[i] = new_flags_s[i];
      end else begin
        flags_d[i] = flags_q[i];
      end
    end
  end

  // Sticky overflow and saturating event counter; a same-cycle clear beats a V event.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
      cnt_d    = {CNT_W{1'b0}};
    end else if (v_event_s) begin
      sticky_d = 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
    end
  end

  // State registers; async reset drops any held result and clears all architectural state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      wr_en_q     <= 1'b0;
      flags_q     <= 4'b0000;
      sticky_q    <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wr_en_q     <= wr_en_d;
      flags_q     <= flags_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign wr_en     = wr_en_q;
  assign flags     = flags_q;
  assign sticky_v  = sticky_q;
  assign ovf_count = cnt_q;

endmodule
